// File: rtl/double_compare_exchange.sv
// Pipelined IEEE-754 double compare-exchange with an inline 2-stage less-than core and a
// credit-protected result FIFO. Optional NaN routing to the hi side under DOUBLE_CX_NAN_EN.
module double_compare_exchange #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_lo,
  output logic [63:0] out_hi,
  output logic        out_swapped,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned LAT = 2;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic in_fire;
  logic push;
  logic pop;
  logic swap;

  assign in_fire = in_valid & in_ready;

  // Less-than core: lt(x, y) with x = b, y = a (arguments flipped when descending).
  logic [63:0] cmp_x;
  logic [63:0] cmp_y;
  logic        x_nan;
  logic        y_nan;

  assign cmp_x = DESCENDING ? in_a : in_b;
  assign cmp_y = DESCENDING ? in_b : in_a;
  assign x_nan = (&cmp_x[62:52]) & (|cmp_x[51:0]);
  assign y_nan = (&cmp_y[62:52]) & (|cmp_y[51:0]);

  logic nan_any_q;
  logic both_zero_q;
  logic sx_q;
  logic sy_q;
  logic mag_lt_q;
  logic mag_gt_q;
  logic lt_q;

  always_ff @(posedge clk) begin
    nan_any_q   <= x_nan | y_nan;
    both_zero_q <= (cmp_x[62:0] == 63'd0) && (cmp_y[62:0] == 63'd0);
    sx_q        <= cmp_x[63];
    sy_q        <= cmp_y[63];
    mag_lt_q    <= cmp_x[62:0] < cmp_y[62:0];
    mag_gt_q    <= cmp_x[62:0] > cmp_y[62:0];
    // Sign-magnitude order; -0 == +0 and any NaN compares false.
    if (nan_any_q || both_zero_q) begin
      lt_q <= 1'b0;
    end else if (sx_q != sy_q) begin
      lt_q <= sx_q;
    end else begin
      lt_q <= sx_q ? mag_gt_q : mag_lt_q;
    end
  end

  // Operand delay in lockstep with the comparator; not reset, qualified by the valid pipe.
  logic [63:0] a_dly_q [LAT];
  logic [63:0] b_dly_q [LAT];

  always_ff @(posedge clk) begin
    a_dly_q[0] <= in_a;
    b_dly_q[0] <= in_b;
    for (int unsigned i = 1; i < LAT; i++) begin
      a_dly_q[i] <= a_dly_q[i-1];
      b_dly_q[i] <= b_dly_q[i-1];
    end
  end

`ifdef DOUBLE_CX_NAN_EN
  logic [LAT-1:0] a_nan_q;
  logic [LAT-1:0] b_nan_q;

  always_ff @(posedge clk) begin
    a_nan_q <= {a_nan_q[LAT-2:0], (&in_a[62:52]) & (|in_a[51:0])};
    b_nan_q <= {b_nan_q[LAT-2:0], (&in_b[62:52]) & (|in_b[51:0])};
  end

  // A lone NaN in a goes to hi; lt_q is already 0 whenever either side is NaN.
  assign swap = lt_q | (a_nan_q[LAT-1] & ~b_nan_q[LAT-1]);
`else
  assign swap = lt_q;
`endif

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [128:0]   entry_in;

  assign vld_d = {vld_q[LAT-2:0], in_fire};
  assign push  = vld_q[LAT-1];

  always_comb begin
    if (swap) begin
      entry_in = {1'b1, b_dly_q[LAT-1], a_dly_q[LAT-1]};
    end else begin
      entry_in = {1'b0, a_dly_q[LAT-1], b_dly_q[LAT-1]};
    end
  end

  // Result FIFO.
  logic [128:0]   mem_q [DEPTH];
  logic [PW-1:0]  wptr_q;
  logic [PW-1:0]  rptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           in_ready_q;
  logic           in_ready_d;
  int unsigned    inflight_d;

  assign out_valid                      = (count_q != '0);
  assign pop                            = out_valid & out_ready;
  assign {out_swapped, out_lo, out_hi}  = mem_q[rptr_q];
  assign in_ready                       = in_ready_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= entry_in;
    end
  end

  // Credits cover everything that will land in the FIFO, so a push never sees it full.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    inflight_d = 0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight_d = inflight_d + 32'(vld_d[i]);
    end
    in_ready_d = (32'(count_d) + inflight_d) < DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

endmodule
